// File: rtl/seq_shifter_if.sv
// Handshake and data bundle for seq_shifter: request side (in_*),
// result side (out_*) and the busy status flag.
interface seq_shifter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA (and ROR when SEQ_SHIFTER_ROTATE_EN is
// defined) applied STEP bits per clock, valid/ready on both sides.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic          clk,
    input logic          rst_n,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SHW:0] LP_STEP = (SHW+1)'(STEP);
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [SHW:0] LP_W = (SHW+1)'(WIDTH);
`endif

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_shifted;
    logic [SHW:0]     r_rem, w_k, w_rem_nxt;
    logic [1:0]       r_mode;
    logic             w_accept;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [SHW:0]     w_rk;
`endif

    // Last step may be shorter than STEP when the amount is not a multiple.
    always_comb begin
        w_k       = (r_rem < LP_STEP) ? r_rem : LP_STEP;
        w_rem_nxt = r_rem - w_k;
    end

`ifdef SEQ_SHIFTER_ROTATE_EN
    assign w_rk = LP_W - w_k;
`endif

    always_comb begin
        w_shifted = r_acc;
        case (r_mode)
            2'b01: w_shifted = r_acc >> w_k;
            2'b10: w_shifted = $signed(r_acc) >>> w_k;
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11: w_shifted = (r_acc >> w_k) | (r_acc << w_rk);
`else
            2'b11: w_shifted = r_acc << w_k;
`endif
            default: w_shifted = r_acc << w_k;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = (bus.in_shamt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_rem_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_mode <= '0;
        end else if (w_accept) begin
            r_acc  <= bus.in_data;
            r_rem  <= {1'b0, bus.in_shamt};
            r_mode <= bus.in_mode;
        end else if (r_state == BUSY) begin
            r_acc  <= w_shifted;
            r_rem  <= w_rem_nxt;
        end
    end

    assign bus.out_data = r_acc;
endmodule
